// File: rtl/bus_fabric.sv
`default_nettype none
// =============================================================================
// Module   : bus_fabric
// Brief    : Single-master address-decode fabric. Routes one master request to
//            one of NUM_SLAVES slaves selected by base/mask regions, registers
//            the slave response back to the master and answers unmapped
//            addresses with an error response. Define BUS_FABRIC_TIMEOUT_EN to
//            also answer unresponsive slaves with an error after
//            TIMEOUT_CYCLES cycles.
// Revision : 1.0 - initial release
// =============================================================================
module bus_fabric #(
   parameter int                           NUM_SLAVES     = 4,
   parameter int                           ADDR_W         = 32,
   parameter int                           DATA_W         = 32,
   parameter logic [NUM_SLAVES*ADDR_W-1:0] BASE           = {32'h8000_0000, 32'h0003_0000,
                                                             32'h0002_0000, 32'h0000_0000},
   parameter logic [NUM_SLAVES*ADDR_W-1:0] MASK           = {32'h8000_0000, 32'h8003_0000,
                                                             32'hFFFF_0000, 32'hFFFE_0000},
   parameter int                           TIMEOUT_CYCLES = 255,
   parameter logic [DATA_W-1:0]            ERR_DATA       = 32'hDEAD_BEEF
) (
   input  logic                         clk,
   input  logic                         reset,
   // master side
   input  logic [ADDR_W-1:0]            m_address,
   input  logic                         m_rw_req,
   input  logic                         m_rw,
   input  logic [DATA_W-1:0]            m_write_data,
   input  logic [1:0]                   m_size,
   output logic [DATA_W-1:0]            m_read_data,
   output logic                         m_rec,
   output logic                         m_err,
   // slave side
   output logic [ADDR_W-1:0]            s_address,
   output logic                         s_rw,
   output logic [DATA_W-1:0]            s_write_data,
   output logic [1:0]                   s_size,
   output logic [NUM_SLAVES-1:0]        s_rw_req,
   input  logic [NUM_SLAVES*DATA_W-1:0] s_read_data,
   input  logic [NUM_SLAVES-1:0]        s_data_valid
);

   localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   // ---------------------------------------------------------------------------
   // Elaboration-time parameter sanity checks
   // ---------------------------------------------------------------------------
   if (NUM_SLAVES < 1 || NUM_SLAVES > 8) begin : g_bad_num_slaves
      $error("bus_fabric: NUM_SLAVES must be in 1..8");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("bus_fabric: TIMEOUT_CYCLES must be at least 1");
   end

   // ---------------------------------------------------------------------------
   // Registered state
   // ---------------------------------------------------------------------------
   state_t                  state_q;
   logic [SEL_W-1:0]        sel_q;
   logic [ADDR_W-1:0]       s_address_q;
   logic                    s_rw_q;
   logic [DATA_W-1:0]       s_write_data_q;
   logic [1:0]              s_size_q;
   logic [NUM_SLAVES-1:0]   s_rw_req_q;
   logic [DATA_W-1:0]       m_read_data_q;
   logic                    m_rec_q;
   logic                    m_err_q;

`ifdef BUS_FABRIC_TIMEOUT_EN
   localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   // The counter holds the number of ACTIVE cycles already spent; the cycle in
   // which it would reach TIMEOUT_CYCLES is the expiry cycle.
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   logic [CNT_W-1:0]             cnt_q;
`endif

   // ---------------------------------------------------------------------------
   // Address decode
   // ---------------------------------------------------------------------------
   logic                    dec_hit;
   logic [SEL_W-1:0]        dec_sel;
   logic [NUM_SLAVES-1:0]   dec_onehot;

   // Scan regions from highest to lowest so the lowest matching index wins.
   always_comb begin
      dec_hit    = 1'b0;
      dec_sel    = '0;
      dec_onehot = '0;
      for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
         if ((m_address & MASK[i*ADDR_W +: ADDR_W]) == BASE[i*ADDR_W +: ADDR_W]) begin
            dec_hit       = 1'b1;
            dec_sel       = SEL_W'(i);
            dec_onehot    = '0;
            dec_onehot[i] = 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Selected-slave response mux: only the latched slave is ever observed
   // ---------------------------------------------------------------------------
   logic [DATA_W-1:0] slv_rdata [NUM_SLAVES];

   for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_slv_rdata
      assign slv_rdata[g] = s_read_data[g*DATA_W +: DATA_W];
   end

   logic              sel_valid;
   logic [DATA_W-1:0] sel_rdata;

   assign sel_valid = s_data_valid[sel_q];
   assign sel_rdata = slv_rdata[sel_q];

   // ---------------------------------------------------------------------------
   // Transaction FSM with registered master and slave outputs
   // ---------------------------------------------------------------------------
   // Sequences IDLE -> ACTIVE -> DONE (or IDLE -> DONE on a decode error).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         sel_q          <= '0;
         s_address_q    <= '0;
         s_rw_q         <= 1'b0;
         s_write_data_q <= '0;
         s_size_q       <= '0;
         s_rw_req_q     <= '0;
         m_read_data_q  <= '0;
         m_rec_q        <= 1'b0;
         m_err_q        <= 1'b0;
`ifdef BUS_FABRIC_TIMEOUT_EN
         cnt_q          <= '0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (m_rw_req) begin
                  if (dec_hit) begin
                     // Latch the whole request so later master changes cannot
                     // disturb the slave while it works.
                     s_address_q    <= m_address;
                     s_rw_q         <= m_rw;
                     s_write_data_q <= m_write_data;
                     s_size_q       <= m_size;
                     sel_q          <= dec_sel;
                     s_rw_req_q     <= dec_onehot;
`ifdef BUS_FABRIC_TIMEOUT_EN
                     cnt_q          <= '0;
`endif
                     state_q        <= ST_ACTIVE;
                  end else begin
                     // Unmapped: answer directly, no slave is touched.
                     m_read_data_q <= ERR_DATA;
                     m_err_q       <= 1'b1;
                     m_rec_q       <= 1'b1;
                     state_q       <= ST_DONE;
                  end
               end
            end

            ST_ACTIVE: begin
               if (sel_valid) begin
                  // A valid response always takes priority over expiry.
                  m_read_data_q <= sel_rdata;
                  m_err_q       <= 1'b0;
                  m_rec_q       <= 1'b1;
                  s_rw_req_q    <= '0;
                  state_q       <= ST_DONE;
               end
`ifdef BUS_FABRIC_TIMEOUT_EN
               else if (cnt_q == CNT_LAST) begin
                  m_read_data_q <= ERR_DATA;
                  m_err_q       <= 1'b1;
                  m_rec_q       <= 1'b1;
                  s_rw_req_q    <= '0;
                  cnt_q         <= cnt_q + 1'b1;
                  state_q       <= ST_DONE;
               end else begin
                  cnt_q         <= cnt_q + 1'b1;
               end
`endif
            end

            ST_DONE: begin
               // Hold the response until the master releases its request, so a
               // level-held request is never issued twice.
               if (!m_rw_req) begin
                  m_rec_q <= 1'b0;
                  m_err_q <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end

            default: begin
               state_q    <= ST_IDLE;
               s_rw_req_q <= '0;
               m_rec_q    <= 1'b0;
               m_err_q    <= 1'b0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Output assignments
   // ---------------------------------------------------------------------------
   assign s_address    = s_address_q;
   assign s_rw         = s_rw_q;
   assign s_write_data = s_write_data_q;
   assign s_size       = s_size_q;
   assign s_rw_req     = s_rw_req_q;
   assign m_read_data  = m_read_data_q;
   assign m_rec        = m_rec_q;
   assign m_err        = m_err_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_fabric.sv
`default_nettype none
// =============================================================================
// Module   : tb_bus_fabric
// Brief    : Self-checking bench for bus_fabric: directed scenarios plus
//            randomized transactions checked against a region-table model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_bus_fabric;

`ifdef BUS_FABRIC_TIMEOUT_EN
   localparam int TB_TIMEOUT = 8;
`else
   localparam int TB_TIMEOUT = 255;
`endif
   localparam logic [31:0] ERR = 32'hDEAD_BEEF;

   logic         clk = 1'b0;
   logic         reset;
   logic [31:0]  m_address;
   logic         m_rw_req;
   logic         m_rw;
   logic [31:0]  m_write_data;
   logic [1:0]   m_size;
   logic [31:0]  m_read_data;
   logic         m_rec;
   logic         m_err;
   logic [31:0]  s_address;
   logic         s_rw;
   logic [31:0]  s_write_data;
   logic [1:0]   s_size;
   logic [3:0]   s_rw_req;
   logic [127:0] s_read_data;
   logic [3:0]   s_data_valid;

   int checks   = 0;
   int failures = 0;
   bit stuck2   = 1'b0;

   bus_fabric #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
      .clk          (clk),
      .reset        (reset),
      .m_address    (m_address),
      .m_rw_req     (m_rw_req),
      .m_rw         (m_rw),
      .m_write_data (m_write_data),
      .m_size       (m_size),
      .m_read_data  (m_read_data),
      .m_rec        (m_rec),
      .m_err        (m_err),
      .s_address    (s_address),
      .s_rw         (s_rw),
      .s_write_data (s_write_data),
      .s_size       (s_size),
      .s_rw_req     (s_rw_req),
      .s_read_data  (s_read_data),
      .s_data_valid (s_data_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Region table: first matching entry wins, -1 when nothing matches.
   function automatic int model_sel(input logic [31:0] a);
      logic [31:0] base [4] = '{32'h0000_0000, 32'h0002_0000, 32'h0003_0000, 32'h8000_0000};
      logic [31:0] mask [4] = '{32'hFFFE_0000, 32'hFFFF_0000, 32'h8003_0000, 32'h8000_0000};
      for (int i = 0; i < 4; i++)
         if ((a & mask[i]) == base[i]) return i;
      return -1;
   endfunction

   // One complete transaction, starting and ending at a falling edge.
   task automatic do_txn(input logic [31:0] addr, input logic rw, input logic [31:0] wdata,
                         input logic [1:0] size, input int lat, input logic [31:0] rdata,
                         input bit drop_early);
      int          sel;
      logic [3:0]  oh;
      logic [31:0] exp_data;
      logic        exp_err;
      bit          dropped;
      sel     = model_sel(addr);
      oh      = (sel >= 0) ? (4'b0001 << sel) : 4'b0000;
      dropped = drop_early && (sel >= 0);
      m_address    = addr;
      m_rw         = rw;
      m_write_data = wdata;
      m_size       = size;
      m_rw_req     = 1'b1;
      @(negedge clk);
      if (sel < 0) begin
         chk("decerr_rec",  m_rec, 1);
         chk("decerr_err",  m_err, 1);
         chk("decerr_data", m_read_data, ERR);
         chk("decerr_sreq", s_rw_req, 0);
         exp_data = ERR;
         exp_err  = 1'b1;
      end else begin
         chk("req_onehot", s_rw_req, oh);
         chk("req_addr",   s_address, addr);
         chk("req_rw",     s_rw, rw);
         chk("req_wdata",  s_write_data, wdata);
         chk("req_size",   s_size, size);
         chk("req_rec",    m_rec, 0);
         // master wanders off while the slave works
         m_write_data = ~wdata;
         m_address    = $urandom;
         m_size       = ~size;
         m_rw         = ~rw;
         if (dropped) m_rw_req = 1'b0;
         for (int k = 0; k < lat; k++) begin
            s_data_valid = (4'($urandom) | (stuck2 ? 4'b0100 : 4'b0000)) & ~oh;
            s_read_data  = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            chk("wait_rec",   m_rec, 0);
            chk("wait_sreq",  s_rw_req, oh);
            chk("wait_wdata", s_write_data, wdata);
            chk("wait_addr",  s_address, addr);
         end
         s_data_valid = 4'($urandom) | oh;
         s_read_data  = {$urandom, $urandom, $urandom, $urandom};
         s_read_data[sel*32 +: 32] = rdata;
         @(negedge clk);
         chk("rsp_rec",  m_rec, 1);
         chk("rsp_err",  m_err, 0);
         chk("rsp_data", m_read_data, rdata);
         chk("rsp_sreq", s_rw_req, 0);
         exp_data = rdata;
         exp_err  = 1'b0;
      end
      s_data_valid = 4'b0000;
      if (!dropped) begin
         @(negedge clk);
         chk("hold_rec",   m_rec, 1);
         chk("hold_err",   m_err, exp_err);
         chk("hold_data",  m_read_data, exp_data);
         chk("no_reissue", s_rw_req, 0);
         m_rw_req = 1'b0;
      end
      @(negedge clk);
      chk("rec_fall", m_rec, 0);
      chk("err_fall", m_err, 0);
      chk("idle_sreq", s_rw_req, 0);
   endtask

   initial begin
      logic [31:0] a;
      reset        = 1'b1;
      m_address    = '0;
      m_rw_req     = 1'b0;
      m_rw         = 1'b0;
      m_write_data = '0;
      m_size       = '0;
      s_read_data  = '0;
      s_data_valid = '0;
      repeat (2) @(negedge clk);
      chk("rst_rec",   m_rec, 0);
      chk("rst_err",   m_err, 0);
      chk("rst_rdata", m_read_data, 0);
      chk("rst_sreq",  s_rw_req, 0);
      chk("rst_addr",  s_address, 0);
      chk("rst_rw",    s_rw, 0);
      chk("rst_wdata", s_write_data, 0);
      chk("rst_size",  s_size, 0);
      reset = 1'b0;
      @(negedge clk);

      // read slave 0, 3-cycle slave latency
      do_txn(32'h0000_1000, 1'b0, 32'h0, 2'd2, 3, 32'h1234_5678, 1'b0);
      // write slave 3 with a mid-ACTIVE write-data change
      do_txn(32'h8000_0004, 1'b1, 32'hCAFE_0001, 2'd2, 4, 32'h0BAD_F00D, 1'b0);
      // unmapped
      do_txn(32'h0004_0000, 1'b0, 32'h0, 2'd0, 0, 32'h0, 1'b0);
      // slave 2 valid stuck high while slave 0 is pending
      stuck2 = 1'b1;
      do_txn(32'h0001_0020, 1'b0, 32'h0, 2'd1, 5, 32'h0A0B_0C0D, 1'b0);
      stuck2 = 1'b0;
      // master drops request during ACTIVE
      do_txn(32'h0003_0010, 1'b0, 32'h0, 2'd2, 2, 32'h7777_1111, 1'b1);
      // zero-latency slave
      do_txn(32'h0002_0008, 1'b1, 32'h1357_9BDF, 2'd3, 0, 32'h2468_ACE0, 1'b0);

      // slave 1 never answers
      m_address = 32'h0002_0040;
      m_rw      = 1'b0;
      m_rw_req  = 1'b1;
      @(negedge clk);
      chk("to_sreq", s_rw_req, 4'b0010);
`ifdef BUS_FABRIC_TIMEOUT_EN
      for (int k = 1; k < TB_TIMEOUT; k++) begin
         @(negedge clk);
         chk("to_wait_rec",  m_rec, 0);
         chk("to_wait_sreq", s_rw_req, 4'b0010);
      end
      @(negedge clk);
      chk("to_rec",  m_rec, 1);
      chk("to_err",  m_err, 1);
      chk("to_data", m_read_data, ERR);
      chk("to_drop", s_rw_req, 0);
`else
      repeat (1000) @(negedge clk);
      chk("nto_rec",  m_rec, 0);
      chk("nto_sreq", s_rw_req, 4'b0010);
      s_read_data[63:32] = 32'h5555_AAAA;
      s_data_valid       = 4'b0010;
      @(negedge clk);
      chk("nto_rsp_rec",  m_rec, 1);
      chk("nto_rsp_data", m_read_data, 32'h5555_AAAA);
      s_data_valid = 4'b0000;
`endif
      m_rw_req = 1'b0;
      @(negedge clk);
      chk("to_rec_fall", m_rec, 0);

      // reset pulsed during ACTIVE
      m_address    = 32'h0000_0100;
      m_write_data = 32'hFACE_FEED;
      m_rw         = 1'b1;
      m_size       = 2'd3;
      m_rw_req     = 1'b1;
      @(negedge clk);
      chk("mr_sreq", s_rw_req, 4'b0001);
      #2 reset = 1'b1;
      #1;
      chk("mr_sreq0",  s_rw_req, 0);
      chk("mr_rec0",   m_rec, 0);
      chk("mr_err0",   m_err, 0);
      chk("mr_rdata0", m_read_data, 0);
      chk("mr_addr0",  s_address, 0);
      chk("mr_wdata0", s_write_data, 0);
      chk("mr_rw0",    s_rw, 0);
      chk("mr_size0",  s_size, 0);
      @(negedge clk);
      reset    = 1'b0;
      m_rw_req = 1'b0;
      @(negedge clk);
      chk("mr_idle_rec", m_rec, 0);
      do_txn(32'h8000_1230, 1'b0, 32'h0, 2'd2, 2, 32'h3C3C_5A5A, 1'b0);

      // randomized traffic
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 5))
            0:       a = {15'h0, 17'($urandom)};
            1:       a = {16'h0002, 16'($urandom)};
            2:       a = {1'b0, 13'($urandom), 2'b11, 16'($urandom)};
            3:       a = {1'b1, 31'($urandom)};
            4:       a = {16'h0004, 16'($urandom)};
            default: a = $urandom;
         endcase
         do_txn(a, 1'($urandom), $urandom, 2'($urandom), $urandom_range(0, 5), $urandom,
                ($urandom_range(0, 3) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
